// File: rtl/alu_seq.sv
// Sequencer that runs an 8-bit op in one pass, or a 16-bit op in two passes,
// through an external combinational byte ALU. The carry is chained from the low pass into the high pass.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wide,
  input  logic [7:0]  op_lo,
  input  logic [7:0]  op_hi,
  input  logic        cin,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_cins,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic [7:0]  alu_out,
  input  logic        alu_carryout,
  input  logic        alu_overout,
  input  logic        alu_cmpo,
  output logic [15:0] result,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_cmp,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
    logic cmp;
  } flags_t;

  state_e      state_q, state_d;
  logic        wide_q, wide_d;
  logic [7:0]  op_lo_q, op_lo_d;
  logic [7:0]  op_hi_q, op_hi_d;
  logic        cin_q, cin_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  lo_res_q, lo_res_d;
  logic        lo_carry_q, lo_carry_d;
  logic [15:0] result_q, result_d;
  flags_t      flags_q, flags_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    wide_d      = wide_q;
    op_lo_d     = op_lo_q;
    op_hi_d     = op_hi_q;
    cin_d       = cin_q;
    a_d         = a_q;
    b_d         = b_q;
    lo_res_d    = lo_res_q;
    lo_carry_d  = lo_carry_q;
    result_d    = result_q;
    flags_d     = flags_q;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_cins    = 8'h00;
    alu_oe      = 1'b0;
    alu_carryin = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wide_d  = wide;
          op_lo_d = op_lo;
          op_hi_d = op_hi;
          cin_d   = cin;
          a_d     = a_in;
          b_d     = b_in;
          state_d = S_LO;
        end
      end
      S_LO: begin
        alu_a       = a_q[7:0];
        alu_b       = b_q[7:0];
        alu_cins    = op_lo_q;
        alu_oe      = 1'b1;
        alu_carryin = cin_q;
        lo_res_d    = alu_out;
        lo_carry_d  = alu_carryout;
        if (wide_q) begin
          state_d = S_HI;
        end else begin
          // Narrow ops publish straight from the low pass with the high byte forced to zero.
          state_d     = S_DONE;
          result_d    = {8'h00, alu_out};
          flags_d.c   = alu_carryout;
          flags_d.v   = alu_overout;
          flags_d.z   = (alu_out == 8'h00);
          flags_d.n   = alu_out[7];
          flags_d.cmp = alu_cmpo;
        end
      end
      S_HI: begin
        alu_a       = a_q[15:8];
        alu_b       = b_q[15:8];
        alu_cins    = op_hi_q;
        alu_oe      = 1'b1;
        alu_carryin = lo_carry_q;
        state_d     = S_DONE;
        result_d    = {alu_out, lo_res_q};
        flags_d.c   = alu_carryout;
        flags_d.v   = alu_overout;
        flags_d.z   = ({alu_out, lo_res_q} == 16'h0000);
        flags_d.n   = alu_out[7];
        flags_d.cmp = alu_cmpo;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated only with non-blocking assignments, so every flop
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      wide_q     <= 1'b0;
      op_lo_q    <= 8'h00;
      op_hi_q    <= 8'h00;
      cin_q      <= 1'b0;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      lo_res_q   <= 8'h00;
      lo_carry_q <= 1'b0;
      result_q   <= 16'h0000;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      wide_q     <= wide_d;
      op_lo_q    <= op_lo_d;
      op_hi_q    <= op_hi_d;
      cin_q      <= cin_d;
      a_q        <= a_d;
      b_q        <= b_d;
      lo_res_q   <= lo_res_d;
      lo_carry_q <= lo_carry_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign result   = result_q;
  assign flag_c   = flags_q.c;
  assign flag_v   = flags_q.v;
  assign flag_z   = flags_q.z;
  assign flag_n   = flags_q.n;
  assign flag_cmp = flags_q.cmp;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule
